// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction-fetch stage
package fetch_pkg;

  localparam int PC_W = 32;

  localparam logic [PC_W-1:0] NOP_WORD_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HOLD,
    DRAIN
  } fetch_state_e;

  typedef struct packed {
    logic [PC_W-1:0] instr;
    logic [PC_W-1:0] npc;
  } if_id_entry_t;

endpackage

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - IF/ID pipeline register with write-enable and flush
module if_id_reg
  import fetch_pkg::*;
#(
  parameter logic [PC_W-1:0] NOP_WORD = NOP_WORD_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            we,
  input  logic            flush,
  input  logic [PC_W-1:0] next_instruction,
  input  logic [PC_W-1:0] next_npc,
  output logic [PC_W-1:0] instruction,
  output logic [PC_W-1:0] npc,
  output logic            valid
);

  // A flush only lands when decode lets the register advance; a stalled
  // decode keeps its current instruction regardless of flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instruction <= '0;
      npc         <= '0;
      valid       <= 1'b0;
    end else if (we) begin
      if (flush) begin
        instruction <= NOP_WORD;
        npc         <= '0;
        valid       <= 1'b0;
      end else begin
        instruction <= next_instruction;
        npc         <= next_npc;
        valid       <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/i_fetch_stage.sv
// rtl/i_fetch_stage.sv - MIPS IF stage: PC, imem handshake, stall/redirect, IF/ID
module i_fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [PC_W-1:0] PC_STEP  = 32'd1,
  parameter logic [PC_W-1:0] NOP_WORD = NOP_WORD_DEFAULT
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            PCWrite_wire,
  input  logic            IFIDWrite_wire,
  input  logic            branchTaken,
  input  logic [PC_W-1:0] add_outWire,
  input  logic            jump_in,
  input  logic [PC_W-1:0] jump_target,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic [PC_W-1:0] imem_rdata,
  output logic [PC_W-1:0] instruction_out,
  output logic [PC_W-1:0] npc_out,
  output logic            valid_out
);

  fetch_state_e    state, state_next;
  logic [PC_W-1:0] pc, pc_next;
  logic [PC_W-1:0] stale_addr, stale_next;
  if_id_entry_t    park, park_next;

  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] redirect_pc;
  logic            redirect;
  logic            done;

  logic            ifid_we;
  logic            ifid_flush;
  logic [PC_W-1:0] ifid_instr;
  logic [PC_W-1:0] ifid_npc;

  assign pc_inc      = pc + PC_STEP;
  assign redirect    = IFIDWrite_wire && (jump_in || branchTaken);
  assign redirect_pc = jump_in ? jump_target : add_outWire;

  // DRAIN keeps the stale request on the bus, at its original address,
  // until memory answers; only then is the new PC presented.
  assign imem_req  = (state == FETCH) || (state == DRAIN);
  assign imem_addr = (state == DRAIN) ? stale_addr : pc;
  assign done      = imem_req && imem_ready;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      stale_addr <= RESET_PC;
      park       <= '0;
    end else begin
      state      <= state_next;
      pc         <= pc_next;
      stale_addr <= stale_next;
      park       <= park_next;
    end
  end

  always_comb begin
    state_next = state;
    pc_next    = pc;
    stale_next = stale_addr;
    park_next  = park;
    ifid_we    = IFIDWrite_wire;
    ifid_flush = 1'b1;
    ifid_instr = imem_rdata;
    ifid_npc   = pc_inc;

    case (state)
      IDLE: begin
        state_next = FETCH;
        if (redirect) pc_next = redirect_pc;
      end

      FETCH: begin
        if (redirect) begin
          pc_next = redirect_pc;
          if (!done) begin
            state_next = DRAIN;
            stale_next = pc;
          end
        end else if (done) begin
          if (PCWrite_wire) pc_next = pc_inc;
          if (IFIDWrite_wire) begin
            ifid_flush = 1'b0;
          end else begin
            park_next  = '{instr: imem_rdata, npc: pc_inc};
            state_next = HOLD;
          end
        end
      end

      // Leaving HOLD moves the PC past the parked word even if the PC was
      // frozen when it arrived, so the word is never fetched twice.
      HOLD: begin
        if (redirect) begin
          pc_next    = redirect_pc;
          state_next = FETCH;
        end else if (IFIDWrite_wire) begin
          ifid_flush = 1'b0;
          ifid_instr = park.instr;
          ifid_npc   = park.npc;
          pc_next    = park.npc;
          state_next = FETCH;
        end
      end

      DRAIN: begin
        if (redirect) pc_next = redirect_pc;
        if (done) state_next = FETCH;
      end

      default: state_next = IDLE;
    endcase
  end

  if_id_reg #(
    .NOP_WORD(NOP_WORD)
  ) u_if_id (
    .clk             (CLK),
    .rst_n           (RST),
    .we              (ifid_we),
    .flush           (ifid_flush),
    .next_instruction(ifid_instr),
    .next_npc        (ifid_npc),
    .instruction     (instruction_out),
    .npc             (npc_out),
    .valid           (valid_out)
  );

endmodule

// File: tb/tb_i_fetch_stage.sv
// tb/tb_i_fetch_stage.sv - scoreboard bench for i_fetch_stage
module tb_i_fetch_stage;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        pcw = 1'b1;
  logic        ifidw = 1'b1;
  logic        br = 1'b0;
  logic        jmp = 1'b0;
  logic [31:0] add_out = '0;
  logic [31:0] jtgt = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [31:0] npc;
  logic        valid;

  logic        req2;
  logic [31:0] addr2;
  logic [31:0] rdata2;
  logic [31:0] instr2;
  logic [31:0] npc2;
  logic        valid2;

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] npc;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  int   wait_cycles = 0;
  int   cnt = 0;
  logic mem_on = 1'b1;
  logic force_ready = 1'b0;
  logic we_q = 1'b0;

  localparam logic [31:0] W0 = 32'h012db820;
  localparam logic [31:0] W1 = 32'h50016bff;
  localparam logic [31:0] W2 = 32'h70060000;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'd0:   mem_word = W0;
      32'd1:   mem_word = W1;
      32'd2:   mem_word = W2;
      default: mem_word = 32'hC0DE0000 | {16'h0, a[15:0]};
    endcase
  endfunction

  assign imem_ready = force_ready || (mem_on && imem_req && (cnt >= wait_cycles));
  assign imem_rdata = force_ready ? 32'hDEADBEEF : mem_word(imem_addr);
  assign rdata2     = 32'h22220000 | {16'h0, addr2[15:0]};

  always @(posedge CLK or negedge RST) begin
    if (!RST) cnt <= 0;
    else if (!imem_req || imem_ready) cnt <= 0;
    else cnt <= cnt + 1;
  end

  always @(posedge CLK) we_q <= ifidw;

  i_fetch_stage dut (
    .CLK            (CLK),
    .RST            (RST),
    .PCWrite_wire   (pcw),
    .IFIDWrite_wire (ifidw),
    .branchTaken    (br),
    .add_outWire    (add_out),
    .jump_in        (jmp),
    .jump_target    (jtgt),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rdata     (imem_rdata),
    .instruction_out(instr),
    .npc_out        (npc),
    .valid_out      (valid)
  );

  i_fetch_stage #(
    .RESET_PC(32'hFFFFFFFF)
  ) dut_wrap (
    .CLK            (CLK),
    .RST            (RST),
    .PCWrite_wire   (1'b1),
    .IFIDWrite_wire (1'b1),
    .branchTaken    (1'b0),
    .add_outWire    (32'h0),
    .jump_in        (1'b0),
    .jump_target    (32'h0),
    .imem_req       (req2),
    .imem_addr      (addr2),
    .imem_ready     (1'b1),
    .imem_rdata     (rdata2),
    .instruction_out(instr2),
    .npc_out        (npc2),
    .valid_out      (valid2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, want);
    end
  endtask

  task automatic push(input logic [31:0] i, input logic [31:0] n);
    exp_t e;
    e.instr = i;
    e.npc   = n;
    exp_q.push_back(e);
  endtask

  // Monitor: a new IF/ID entry is presented when decode let the register
  // advance on the last edge and the register now holds a real instruction.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (RST && we_q && valid) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL sb_unexpected: got %h npc %h expected no word", instr, npc);
        end else begin
          e = exp_q.pop_front();
          check("sb_instr", instr, e.instr);
          check("sb_npc", npc, e.npc);
        end
      end
    end
  end

  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic do_reset();
    RST = 1'b0;
    pcw = 1'b1;
    ifidw = 1'b1;
    br = 1'b0;
    jmp = 1'b0;
    add_out = '0;
    jtgt = '0;
    force_ready = 1'b0;
    mem_on = 1'b1;
    wait_cycles = 0;
    repeat (2) tick();
  endtask

  task automatic drained(input string name);
    check(name, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // zero-wait stream plus wrap-around reset PC instance
    do_reset();
    check("rst_req", imem_req, 0);
    check("rst_addr", imem_addr, 0);
    check("rst_instr", instr, 0);
    check("rst_npc", npc, 0);
    check("rst_valid", valid, 0);
    check("rst_wrap_addr", addr2, 32'hFFFFFFFF);
    push(W0, 1); push(W1, 2); push(W2, 3);
    RST = 1'b1;
    tick();
    check("s1_req", imem_req, 1);
    check("s1_addr0", imem_addr, 0);
    check("s1_wrap_addr0", addr2, 32'hFFFFFFFF);
    tick();
    check("s1_addr1", imem_addr, 1);
    check("s1_wrap_addr1", addr2, 32'h0);
    check("s1_wrap_npc", npc2, 32'h0);
    check("s1_wrap_instr", instr2, 32'h2222FFFF);
    check("s1_wrap_valid", valid2, 1);
    tick();
    check("s1_addr2", imem_addr, 2);
    tick();
    mem_on = 1'b0;
    tick();
    check("s1_bubble", valid, 0);
    drained("s1_drained");

    // three-cycle stall while IF/ID holds the first word
    do_reset();
    push(W0, 1); push(W1, 2); push(W2, 3);
    RST = 1'b1;
    tick();
    tick();
    check("s2_pre_instr", instr, W0);
    check("s2_pre_addr", imem_addr, 1);
    ifidw = 1'b0;
    pcw = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("s2_hold_instr", instr, W0);
      check("s2_hold_valid", valid, 1);
      check("s2_hold_req", imem_req, 0);
    end
    ifidw = 1'b1;
    pcw = 1'b1;
    tick();
    check("s2_resume_addr", imem_addr, 2);
    check("s2_resume_req", imem_req, 1);
    tick();
    mem_on = 1'b0;
    tick();
    drained("s2_drained");

    // branch at PC=5 to 0x40
    do_reset();
    push(W0, 1); push(W1, 2); push(W2, 3);
    push(32'hC0DE0003, 4); push(32'hC0DE0004, 5); push(32'hC0DE0040, 32'h41);
    RST = 1'b1;
    repeat (6) tick();
    check("s3_addr5", imem_addr, 5);
    br = 1'b1;
    add_out = 32'h40;
    tick();
    br = 1'b0;
    check("s3_flush_instr", instr, 0);
    check("s3_flush_npc", npc, 0);
    check("s3_flush_valid", valid, 0);
    check("s3_target_addr", imem_addr, 32'h40);
    tick();
    mem_on = 1'b0;
    tick();
    drained("s3_drained");

    // three wait states, redirect in second wait cycle of the next request
    do_reset();
    wait_cycles = 3;
    push(W0, 1); push(32'hC0DE0080, 32'h81);
    RST = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("s4_stable_addr", imem_addr, 0);
      check("s4_wait_valid", valid, 0);
    end
    tick();
    check("s4_addr1", imem_addr, 1);
    tick();
    check("s4_addr1_w2", imem_addr, 1);
    br = 1'b1;
    add_out = 32'h80;
    tick();
    br = 1'b0;
    check("s4_drain_addr", imem_addr, 1);
    check("s4_drain_req", imem_req, 1);
    check("s4_drain_valid", valid, 0);
    tick();
    check("s4_drain_addr2", imem_addr, 1);
    tick();
    check("s4_discard_valid", valid, 0);
    check("s4_target_addr", imem_addr, 32'h80);
    check("s4_target_req", imem_req, 1);
    repeat (4) tick();
    mem_on = 1'b0;
    tick();
    drained("s4_drained");

    // jump and branch together: jump wins
    do_reset();
    push(W0, 1); push(32'hC0DE0100, 32'h101);
    RST = 1'b1;
    tick();
    tick();
    check("s5_addr1", imem_addr, 1);
    jmp = 1'b1;
    jtgt = 32'h100;
    br = 1'b1;
    add_out = 32'h40;
    tick();
    jmp = 1'b0;
    br = 1'b0;
    check("s5_jump_addr", imem_addr, 32'h100);
    check("s5_flush_valid", valid, 0);
    tick();
    mem_on = 1'b0;
    tick();
    drained("s5_drained");

    // reset in the middle of an outstanding request, then a late ready
    do_reset();
    push(W0, 1); push(W0, 1);
    RST = 1'b1;
    tick();
    tick();
    ifidw = 1'b0;
    pcw = 1'b0;
    wait_cycles = 3;
    tick();
    check("s6_pre_instr", instr, W0);
    check("s6_pre_req", imem_req, 1);
    check("s6_pre_addr", imem_addr, 1);
    #2;
    RST = 1'b0;
    #1;
    check("s6_rst_req", imem_req, 0);
    check("s6_rst_addr", imem_addr, 0);
    check("s6_rst_instr", instr, 0);
    check("s6_rst_npc", npc, 0);
    check("s6_rst_valid", valid, 0);
    ifidw = 1'b1;
    pcw = 1'b1;
    wait_cycles = 0;
    force_ready = 1'b1;
    tick();
    check("s6_late_rst_valid", valid, 0);
    RST = 1'b1;
    tick();
    check("s6_late_valid", valid, 0);
    check("s6_late_instr", instr, 0);
    check("s6_late_req", imem_req, 1);
    check("s6_late_addr", imem_addr, 0);
    force_ready = 1'b0;
    tick();
    mem_on = 1'b0;
    tick();
    drained("s6_drained");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
